// File: rtl/mod_n_counter.sv
// Parametrised modulo-N up/down counter with parallel load, wrap or saturate
// at the limits, combinational terminal count, sticky overflow and a Gray copy.
module mod_n_counter #(
    parameter int N        = 4,
    parameter int MODULUS  = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         up_dn,
    input  logic         load,
    input  logic [N-1:0] d,
    input  logic         clr_ovf,
    output logic [N-1:0] Q,
    output logic [N-1:0] Q_gray,
    output logic         tc,
    output logic         ovf
);

    if (MODULUS < 2 || MODULUS > (1 << N)) begin : g_bad_modulus
        $error("mod_n_counter: MODULUS must satisfy 2 <= MODULUS <= 2**N");
    end

    localparam logic [N-1:0] MAX_COUNT = N'(MODULUS - 1);

    logic         at_max;
    logic         at_zero;
    logic         limit_hit;
    logic [N-1:0] load_value;
    logic [N-1:0] q_next;
    logic         ovf_next;

    // A limit event is an enabled count step that would leave the range;
    // load pre-empts counting, so it also masks tc and the overflow set.
    always_comb begin
        at_max     = (Q == MAX_COUNT);
        at_zero    = (Q == '0);
        limit_hit  = en & ~load & (up_dn ? at_max : at_zero);
        tc         = limit_hit;
        load_value = (d > MAX_COUNT) ? MAX_COUNT : d;
        q_next     = Q;
        if (load) begin
            q_next = load_value;
        end else if (en) begin
            if (up_dn) begin
                if (at_max) begin
                    q_next = SATURATE ? Q : '0;
                end else begin
                    q_next = Q + 1'b1;
                end
            end else begin
                if (at_zero) begin
                    q_next = SATURATE ? Q : MAX_COUNT;
                end else begin
                    q_next = Q - 1'b1;
                end
            end
        end
        ovf_next = limit_hit | (ovf & ~clr_ovf);
    end

    // Gray is derived from the next binary value so both registers agree.
    always_ff @(posedge clk) begin
        if (reset) begin
            Q      <= '0;
            Q_gray <= '0;
            ovf    <= 1'b0;
        end else begin
            Q      <= q_next;
            Q_gray <= q_next ^ (q_next >> 1);
            ovf    <= ovf_next;
        end
    end

endmodule

// File: tb/tb_mod_n_counter.sv
// Self-checking bench for mod_n_counter: a wrapping and a saturating instance
// (N=4, MODULUS=10) share stimulus and are compared against an arithmetic model.
module tb_mod_n_counter;

    localparam int M = 10;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] d;
    logic       clr_ovf;

    logic [3:0] q_w, g_w, q_s, g_s;
    logic       tc_w, ovf_w, tc_s, ovf_s;

    int vectors;
    int miscompares;

    // Model state: index 0 is the wrapping counter, index 1 the saturating one.
    int mq[2];
    bit movf[2];

    mod_n_counter #(.N(4), .MODULUS(M), .SATURATE(1'b0)) dut_w (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .d(d),
        .clr_ovf(clr_ovf), .Q(q_w), .Q_gray(g_w), .tc(tc_w), .ovf(ovf_w)
    );

    mod_n_counter #(.N(4), .MODULUS(M), .SATURATE(1'b1)) dut_s (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .d(d),
        .clr_ovf(clr_ovf), .Q(q_s), .Q_gray(g_s), .tc(tc_s), .ovf(ovf_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] gray_of(input int value);
        logic [3:0] b;
        b = 4'(value);
        return b ^ (b >> 1);
    endfunction

    function automatic bit model_tc(input int q);
        return en && !load && (up_dn ? (q == M - 1) : (q == 0));
    endfunction

    // Advances the reference model by one edge using the counting rules.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            bit limit;
            limit = model_tc(mq[k]);
            if (reset) begin
                mq[k]   = 0;
                movf[k] = 1'b0;
            end else begin
                if (load) begin
                    mq[k] = (int'(d) > M - 1) ? M - 1 : int'(d);
                end else if (en) begin
                    if (up_dn) mq[k] = (k == 1) ? ((mq[k] + 1 > M - 1) ? M - 1 : mq[k] + 1)
                                                : (mq[k] + 1) % M;
                    else       mq[k] = (k == 1) ? ((mq[k] - 1 < 0) ? 0 : mq[k] - 1)
                                                : (mq[k] + M - 1) % M;
                end
                if (limit) movf[k] = 1'b1;
                else if (clr_ovf) movf[k] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; up_dn = 1'b1; load = 1'b0; d = 4'd0; clr_ovf = 1'b0;
        tick();
        tick();
        vectors++;
        if (q_w !== 4'd0 || g_w !== 4'd0 || ovf_w !== 1'b0 || tc_w !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_wrap: got Q=%0d gray=%b ovf=%b tc=%b, want 0 0000 0 0",
                     q_w, g_w, ovf_w, tc_w);
        end
        vectors++;
        if (q_s !== 4'd0 || g_s !== 4'd0 || ovf_s !== 1'b0 || tc_s !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_sat: got Q=%0d gray=%b ovf=%b tc=%b, want 0 0000 0 0",
                     q_s, g_s, ovf_s, tc_s);
        end
    endtask

    task automatic test_up_wrap();
        reset = 1'b0; en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 11; i++) begin
            #1;
            vectors++;
            if (tc_w !== (mq[0] == 9)) begin
                miscompares++;
                $display("[TB] FAIL up_tc step %0d: got %b, want %b", i, tc_w, mq[0] == 9);
            end
            tick();
            vectors++;
            if (q_w !== 4'((i + 1) % 10) || ovf_w !== (i >= 9) || g_w !== gray_of(mq[0])) begin
                miscompares++;
                $display("[TB] FAIL up_wrap step %0d: got Q=%0d ovf=%b gray=%b, want Q=%0d ovf=%b gray=%b",
                         i, q_w, ovf_w, g_w, (i + 1) % 10, i >= 9, gray_of(mq[0]));
            end
            if (i == 4 || i == 8) begin
                vectors++;
                if (g_w !== ((i == 4) ? 4'b0111 : 4'b1101)) begin
                    miscompares++;
                    $display("[TB] FAIL up_gray_const Q=%0d: got %b", q_w, g_w);
                end
            end
        end
    endtask

    task automatic test_down_dir();
        reset = 1'b1;
        tick();
        reset = 1'b0; up_dn = 1'b0; en = 1'b1;
        #1;
        vectors++;
        if (tc_w !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL down_tc_at_zero: got %b, want 1", tc_w);
        end
        tick();
        vectors++;
        if (q_w !== 4'd9 || ovf_w !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL down_wrap: got Q=%0d ovf=%b, want Q=9 ovf=1", q_w, ovf_w);
        end
        en = 1'b0; clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        vectors++;
        if (ovf_w !== 1'b0 || q_w !== 4'd9) begin
            miscompares++;
            $display("[TB] FAIL down_clr_ovf: got Q=%0d ovf=%b, want Q=9 ovf=0", q_w, ovf_w);
        end
        en = 1'b1;
        tick();
        tick();
        vectors++;
        if (q_w !== 4'd7) begin
            miscompares++;
            $display("[TB] FAIL down_to_7: got Q=%0d, want 7", q_w);
        end
        up_dn = 1'b1;
        tick();
        vectors++;
        if (q_w !== 4'd8 || ovf_w !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL dir_change: got Q=%0d ovf=%b, want Q=8 ovf=0", q_w, ovf_w);
        end
    endtask

    task automatic test_load();
        bit ovf_before;
        en = 1'b1; up_dn = 1'b1;
        tick();
        load = 1'b1; d = 4'd4;
        ovf_before = movf[0];
        #1;
        vectors++;
        if (tc_w !== 1'b0 || q_w !== 4'd9) begin
            miscompares++;
            $display("[TB] FAIL load_tc: got tc=%b Q=%0d, want tc=0 Q=9", tc_w, q_w);
        end
        tick();
        vectors++;
        if (q_w !== 4'd4 || ovf_w !== ovf_before) begin
            miscompares++;
            $display("[TB] FAIL load_4: got Q=%0d ovf=%b, want Q=4 ovf=%b", q_w, ovf_w, ovf_before);
        end
        d = 4'd12;
        tick();
        vectors++;
        if (q_w !== 4'd9 || g_w !== 4'b1101) begin
            miscompares++;
            $display("[TB] FAIL load_clamp_12: got Q=%0d gray=%b, want Q=9 gray=1101", q_w, g_w);
        end
        d = 4'd0;
        tick();
        d = 4'd15;
        tick();
        vectors++;
        if (q_w !== 4'd9 || q_s !== 4'd9) begin
            miscompares++;
            $display("[TB] FAIL load_clamp_15: got Qw=%0d Qs=%0d, want 9 9", q_w, q_s);
        end
        load = 1'b0;
    endtask

    task automatic test_saturate();
        reset = 1'b1;
        tick();
        reset = 1'b0; en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            vectors++;
            if (q_s !== 4'((i + 1 > 9) ? 9 : i + 1) || ovf_s !== (i >= 9) || g_s !== gray_of(mq[1])) begin
                miscompares++;
                $display("[TB] FAIL sat_up step %0d: got Q=%0d ovf=%b gray=%b, want Q=%0d ovf=%b",
                         i, q_s, ovf_s, g_s, (i + 1 > 9) ? 9 : i + 1, i >= 9);
            end
        end
        clr_ovf = 1'b1;
        tick();
        vectors++;
        if (ovf_s !== 1'b1 || q_s !== 4'd9) begin
            miscompares++;
            $display("[TB] FAIL sat_set_beats_clr: got Q=%0d ovf=%b, want Q=9 ovf=1", q_s, ovf_s);
        end
        en = 1'b0;
        tick();
        clr_ovf = 1'b0;
        vectors++;
        if (ovf_s !== 1'b0 || q_s !== 4'd9) begin
            miscompares++;
            $display("[TB] FAIL sat_clr: got Q=%0d ovf=%b, want Q=9 ovf=0", q_s, ovf_s);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0; en = 1'b1; up_dn = 1'b0;
        tick();
        vectors++;
        if (q_s !== 4'd0 || ovf_s !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL sat_down_hold: got Q=%0d ovf=%b, want Q=0 ovf=1", q_s, ovf_s);
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        tick();
        reset = 1'b0; en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        vectors++;
        if (q_w !== 4'd6 || ovf_w !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_setup: got Q=%0d ovf=%b, want Q=6 ovf=1", q_w, ovf_w);
        end
        reset = 1'b1; load = 1'b1; d = 4'd3;
        tick();
        vectors++;
        if (q_w !== 4'd0 || ovf_w !== 1'b0 || g_w !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset: got Q=%0d ovf=%b gray=%b, want 0 0 0000", q_w, ovf_w, g_w);
        end
        reset = 1'b0; load = 1'b0;
        tick();
        vectors++;
        if (q_w !== 4'd1) begin
            miscompares++;
            $display("[TB] FAIL mid_resume: got Q=%0d, want 1", q_w);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset   = ($urandom_range(0, 31) == 0);
            en      = ($urandom_range(0, 3) != 0);
            up_dn   = $urandom_range(0, 1) == 1;
            load    = ($urandom_range(0, 7) == 0);
            d       = 4'($urandom_range(0, 15));
            clr_ovf = ($urandom_range(0, 5) == 0);
            #1;
            vectors++;
            if (tc_w !== model_tc(mq[0]) || tc_s !== model_tc(mq[1])) begin
                miscompares++;
                $display("[TB] FAIL rand_tc cycle %0d: got w=%b s=%b, want w=%b s=%b",
                         i, tc_w, tc_s, model_tc(mq[0]), model_tc(mq[1]));
            end
            tick();
            vectors++;
            if (q_w !== 4'(mq[0]) || g_w !== gray_of(mq[0]) || ovf_w !== movf[0]) begin
                miscompares++;
                $display("[TB] FAIL rand_wrap cycle %0d: got Q=%0d gray=%b ovf=%b, want Q=%0d gray=%b ovf=%b",
                         i, q_w, g_w, ovf_w, mq[0], gray_of(mq[0]), movf[0]);
            end
            vectors++;
            if (q_s !== 4'(mq[1]) || g_s !== gray_of(mq[1]) || ovf_s !== movf[1]) begin
                miscompares++;
                $display("[TB] FAIL rand_sat cycle %0d: got Q=%0d gray=%b ovf=%b, want Q=%0d gray=%b ovf=%b",
                         i, q_s, g_s, ovf_s, mq[1], gray_of(mq[1]), movf[1]);
            end
        end
        reset = 1'b0; load = 1'b0; clr_ovf = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        mq[0] = 0; mq[1] = 0;
        movf[0] = 1'b0; movf[1] = 1'b0;
        test_reset();
        test_up_wrap();
        test_down_dir();
        test_load();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mod_n_counter.md
# mod_n_counter

Parametrised synchronous modulo-N counter. It is the general-purpose successor to the fixed 4-bit free-running counter, used wherever the design needs a counter with a modulus other than a power of two. It adds up/down counting, count enable, parallel load, and a choice of wrap or saturate at the limits. It also provides a combinational terminal-count output for cascading stages, a sticky overflow flag and a registered Gray-coded copy of the count.

## Interface

Parameters:

- `N`, 4: counter width in bits.
- `MODULUS`, 16: count range is 0 .. MODULUS-1. Legal range is 2 <= MODULUS <= 2^N. Any other value is an elaboration error.
- `SATURATE`, 0: at a limit, 0 wraps around and 1 holds the value.

Ports (clock and reset first):

- `clk`  in  1  rising-edge clock; the single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  count enable.
- `up_dn`  in  1  1 counts up, 0 counts down.
- `load`  in  1  parallel load strobe.
- `d`  in  N  parallel load value.
- `clr_ovf`  in  1  clears the sticky overflow flag.
- `Q`  out  N  binary count, registered.
- `Q_gray`  out  N  Gray code of Q, registered; always equals Q ^ (Q >> 1).
- `tc`  out  1  terminal count, combinational.
- `ovf`  out  1  sticky overflow/limit flag, registered.

## Operation

Per-edge priority, highest first: reset > load > en > hold.

- **reset = 1:** Q = 0, Q_gray = 0, ovf = 0. All other inputs are ignored.
- **load = 1:** Q = d when d <= MODULUS-1. Otherwise Q = MODULUS-1 (clamped). A load never sets ovf.
- **en = 1, up_dn = 1, Q < MODULUS-1:** Q = Q+1.
- **en = 1, up_dn = 1, Q = MODULUS-1:**
  - SATURATE=0: Q = 0.
  - SATURATE=1: Q holds.
  - ovf is set in both modes.
- **en = 1, up_dn = 0, Q > 0:** Q = Q-1.
- **en = 1, up_dn = 0, Q = 0:**
  - SATURATE=0: Q = MODULUS-1.
  - SATURATE=1: Q holds.
  - ovf is set in both modes.
- **en = 0, load = 0:** Q holds.
- **Gray output:** Q_gray is computed from the next value of Q and registered on the same edge. Q and Q_gray never disagree in any cycle.
- **tc** = en & ~load & ((up_dn & Q == MODULUS-1) | (~up_dn & Q == 0)). It flags the cycle in which the next edge reaches a limit.
- **ovf:**
  - Set by a limit event.
  - Cleared by clr_ovf.
  - If a limit event and clr_ovf occur on the same edge, set wins and ovf = 1.
  - Only reset overrides a set.
- **Arithmetic:** all comparisons are unsigned, N bits wide. No intermediate value exceeds 2^N-1.
- **Cascading:** feed stage k+1 `en` from stage k `tc`. Both stages share the same up_dn.

## Timing

- Latency: one clock from a load, en or reset input to Q, Q_gray and ovf.
- tc has zero-cycle latency; it is a combinational function of the current Q, en, load and up_dn.
- Output values after reset: Q = 0, Q_gray = 0, ovf = 0. tc = en & ~up_dn (Q = 0 is the down-count limit).
- Reset mid-count takes effect at the first rising edge with reset = 1, regardless of en or load.
- Inputs are sampled only at the rising edge of clk. There are no asynchronous paths.
- A direction change takes effect on the next edge; no turnaround cycle is inserted.

## Test plan

All scenarios use N=4, MODULUS=10, SATURATE=0 unless stated otherwise.

1. **Reset:** assert reset for 2 edges with en=1, up_dn=1.
   - Required: Q=0, Q_gray=0, ovf=0, tc=0.
2. **Up count with wrap:** from Q=0, en=1, up_dn=1 for 11 edges.
   - Q steps through 1..9, then 0, then 1.
   - tc=1 only while Q=9.
   - ovf=1 from the edge where Q goes 9 -> 0.
   - Q_gray tracks Q; e.g. Q=5 gives Q_gray=0111 and Q=9 gives Q_gray=1101.
3. **Down count and direction change:** from Q=0, up_dn=0, en=1.
   - tc=1 at Q=0; the next edge gives Q=9 and ovf=1.
   - Pulse clr_ovf: ovf=0.
   - Toggle up_dn=1 at Q=7: the next edge gives Q=8.
4. **Load:** apply load=1, d=4 together with en=1.
   - Required: Q=4 (load beats en), ovf unchanged, tc=0 during the load cycle.
   - Then load d=12: Q=9 (clamped).
5. **Saturate mode (SATURATE=1):** en=1, up_dn=1 for 12 edges from 0.
   - Q sticks at 9 and ovf=1.
   - Apply clr_ovf on the same edge as another limit attempt: ovf stays 1.
   - Apply clr_ovf with en=0: ovf=0.
6. **Reset mid-operation:** at Q=6, ovf=1, assert reset together with load=1, d=3.
   - Required: Q=0 and ovf=0 on that edge.
   - After release, counting resumes from 0 with Q=1 on the next enabled edge.
